// File: rtl/dr_ext.sv
// Load-data extraction/extension for the MEM stage: selects a byte or halfword lane,
// sign/zero-extends it, and flags misaligned accesses; registered copies are provided.
module dr_ext (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic [1:0]  low_addr,
    input  logic        exsign,
    input  logic        isByte,
    input  logic        isHalf,
    output logic [31:0] out_data,
    output logic        misalign,
    output logic [31:0] out_data_q,
    output logic        misalign_q
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_data;
    logic        w_mis;
    logic [31:0] r_data;
    logic        r_mis;

    always_comb begin
        w_byte = '0;
        unique case (low_addr)
            2'd0: w_byte = in_data[7:0];
            2'd1: w_byte = in_data[15:8];
            2'd2: w_byte = in_data[23:16];
            2'd3: w_byte = in_data[31:24];
            default: w_byte = '0;
        endcase
        w_half = low_addr[1] ? in_data[31:16] : in_data[15:0];
    end

    // Byte decode has priority over halfword when both flags are set.
    always_comb begin
        w_data = in_data;
        w_mis  = 1'b0;
        if (isByte) begin
            w_data = {{24{exsign & w_byte[7]}}, w_byte};
            w_mis  = 1'b0;
        end else if (isHalf) begin
            w_data = {{16{exsign & w_half[15]}}, w_half};
            w_mis  = low_addr[0];
        end else begin
            w_data = in_data;
            w_mis  = (low_addr != 2'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_mis  <= 1'b0;
        end else begin
            r_data <= w_data;
            r_mis  <= w_mis;
        end
    end

    assign out_data   = w_data;
    assign misalign   = w_mis;
    assign out_data_q = r_data;
    assign misalign_q = r_mis;

endmodule

// File: tb/tb_dr_ext.sv
// Scoreboard bench for dr_ext: stimulus pushes expected responses, a monitor pops and compares.
module tb_dr_ext;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  low_addr;
    logic        exsign;
    logic        isByte;
    logic        isHalf;
    logic [31:0] out_data;
    logic        misalign;
    logic [31:0] out_data_q;
    logic        misalign_q;

    typedef struct {
        string       name;
        logic        is_reg;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    logic chk_req;
    int   n_tests;
    int   n_fail;

    dr_ext dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .low_addr   (low_addr),
        .exsign     (exsign),
        .isByte     (isByte),
        .isHalf     (isHalf),
        .out_data   (out_data),
        .misalign   (misalign),
        .out_data_q (out_data_q),
        .misalign_q (misalign_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input string nm, input logic rg, input logic [31:0] ed, input logic em);
        exp_t e;
        e.name   = nm;
        e.is_reg = rg;
        e.data   = ed;
        e.mis    = em;
        sb.push_back(e);
        chk_req = ~chk_req;
        #1;
    endtask

    task automatic comb(input string nm, input logic b, input logic h, input logic [1:0] a,
                        input logic s, input logic [31:0] ed, input logic em);
        @(negedge clk);
        isByte   = b;
        isHalf   = h;
        low_addr = a;
        exsign   = s;
        #2;
        push_exp(nm, 1'b0, ed, em);
    endtask

    task automatic drive(input logic b, input logic h, input logic [1:0] a, input logic s);
        @(negedge clk);
        isByte   = b;
        isHalf   = h;
        low_addr = a;
        exsign   = s;
    endtask

    task automatic regchk(input string nm, input logic [31:0] ed, input logic em);
        push_exp(nm, 1'b1, ed, em);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] ad;
        logic        am;
        forever begin
            @(chk_req);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: no expected entry queued");
            end else begin
                e  = sb.pop_front();
                ad = e.is_reg ? out_data_q : out_data;
                am = e.is_reg ? misalign_q : misalign;
                if (ad !== e.data || am !== e.mis) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h mis=%b, expected data=%h mis=%b",
                             e.name, ad, am, e.data, e.mis);
                end
            end
        end
    end

    initial begin : stim
        chk_req  = 1'b0;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        in_data  = 32'h8A7B_C3D4;
        low_addr = 2'd0;
        exsign   = 1'b0;
        isByte   = 1'b0;
        isHalf   = 1'b0;

        @(negedge clk);
        regchk("reset_state", 32'h0, 1'b0);
        comb("comb_in_reset", 1'b1, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFD4, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        comb("byte_s_a0", 1'b1, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFD4, 1'b0);
        comb("byte_s_a1", 1'b1, 1'b0, 2'd1, 1'b1, 32'hFFFF_FFC3, 1'b0);
        comb("byte_s_a2", 1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_007B, 1'b0);
        comb("byte_s_a3", 1'b1, 1'b0, 2'd3, 1'b1, 32'hFFFF_FF8A, 1'b0);
        comb("byte_u_a0", 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_00D4, 1'b0);
        comb("byte_u_a1", 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_00C3, 1'b0);
        comb("byte_u_a2", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_007B, 1'b0);
        comb("byte_u_a3", 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_008A, 1'b0);
        comb("half_s_a0", 1'b0, 1'b1, 2'd0, 1'b1, 32'hFFFF_C3D4, 1'b0);
        comb("half_s_a2", 1'b0, 1'b1, 2'd2, 1'b1, 32'hFFFF_8A7B, 1'b0);
        comb("half_u_a2", 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_8A7B, 1'b0);
        comb("half_u_a0", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_C3D4, 1'b0);
        comb("half_s_a1", 1'b0, 1'b1, 2'd1, 1'b1, 32'hFFFF_C3D4, 1'b1);
        comb("half_s_a3", 1'b0, 1'b1, 2'd3, 1'b1, 32'hFFFF_8A7B, 1'b1);
        comb("word_a0_s1", 1'b0, 1'b0, 2'd0, 1'b1, 32'h8A7B_C3D4, 1'b0);
        comb("word_a0_s0", 1'b0, 1'b0, 2'd0, 1'b0, 32'h8A7B_C3D4, 1'b0);
        comb("word_a2", 1'b0, 1'b0, 2'd2, 1'b0, 32'h8A7B_C3D4, 1'b1);
        comb("word_a1", 1'b0, 1'b0, 2'd1, 1'b1, 32'h8A7B_C3D4, 1'b1);
        comb("prio_byte_half", 1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_00C3, 1'b0);

        drive(1'b1, 1'b0, 2'd3, 1'b1);
        @(posedge clk); #1;
        regchk("reg_byte_a3", 32'hFFFF_FF8A, 1'b0);
        drive(1'b0, 1'b1, 2'd1, 1'b1);
        @(posedge clk); #1;
        regchk("reg_half_a1", 32'hFFFF_C3D4, 1'b1);

        drive(1'b1, 1'b0, 2'd3, 1'b1);
        @(posedge clk); #1;
        regchk("reg_pre_reset", 32'hFFFF_FF8A, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        regchk("reg_async_reset", 32'h0, 1'b0);
        @(posedge clk); #1;
        regchk("reg_hold_reset1", 32'h0, 1'b0);
        drive(1'b0, 1'b1, 2'd3, 1'b0);
        @(posedge clk); #1;
        regchk("reg_hold_reset2", 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        regchk("reg_no_cap_at_release", 32'h0, 1'b0);
        @(posedge clk); #1;
        regchk("reg_reload", 32'h0000_8A7B, 1'b1);

        #5;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
